// File: rtl/regfile_pkg.sv
// Shared widths, write-back bundle and pending-counter helper
// for the register-file write side.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int PEND_W     = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_LOAD
  } wb_sel_e;

  // Saturates at both ends; a same-edge inc/dec cancels out.
  function automatic logic [PEND_W-1:0] pend_next(
    input logic [PEND_W-1:0] cur,
    input logic              inc,
    input logic              dec
  );
    logic [PEND_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != '1)
      nxt = cur + PEND_W'(1);
    else if (dec && !inc && cur != '0)
      nxt = cur - PEND_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result FIFO of {rd, data}; pointers carry an extra
// wrap bit to tell full from empty.
module wb_load_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  wb_t  push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output wb_t  head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  wb_t         mem_q [DEPTH];
  logic [PW:0] wr_q;
  logic [PW:0] wr_d;
  logic [PW:0] rd_q;
  logic [PW:0] rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head  = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full)
      wr_d = wr_q + PTR_ONE;
    if (pop && !empty)
      rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !full)
      mem_q[wr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: ALU vs buffered loads,
// plus the per-register pending-write scoreboard.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int LOAD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0]     data_in
);

  wb_t     push_data;
  wb_t     head;
  logic    full;
  logic    empty;
  logic    push;
  logic    pop;
  wb_sel_e sel;

  logic                  we_q;
  logic                  we_d;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W-1:0]     data_d;

  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];

  assign mem_ready = !full && !reset;
  assign alu_stall = full && !reset;
  assign push      = mem_valid && mem_ready;
  assign push_data = '{rd: mem_rd, data: mem_data};

  wb_load_fifo #(
    .DEPTH(LOAD_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  // A full FIFO wins so the load path can never deadlock.
  always_comb begin
    sel = SEL_NONE;
    if (!reset) begin
      if (full)
        sel = SEL_LOAD;
      else if (alu_valid)
        sel = SEL_ALU;
      else if (!empty)
        sel = SEL_LOAD;
    end
  end

  assign pop = (sel == SEL_LOAD);

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (sel)
      SEL_ALU: begin
        we_d   = 1'b1;
        addr_d = alu_rd;
        data_d = alu_data;
      end
      SEL_LOAD: begin
        we_d   = 1'b1;
        addr_d = head.rd;
        data_d = head.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign data_in       = data_q;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = pend_next(
        cnt_q[r],
        issue_valid && (issue_rd == REG_ADDR_W'(r)),
        we_d && (addr_d == REG_ADDR_W'(r))
      );
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset)
        cnt_q[r] <= '0;
      else
        cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      busy_mask[r] = (cnt_q[r] != '0);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed vectors
// plus random traffic against a reference model.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy_mask;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] data_in;

  regfile_writeback #(.LOAD_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_stall    (alu_stall),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .busy_mask    (busy_mask),
    .write_enable (write_enable),
    .write_address(write_address),
    .data_in      (data_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pushed;
  logic [36:0] mq[$];
  logic [36:0] exp_q[$];
  int cnt[32];
  bit alu_taken;
  bit mem_taken;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model, evaluated on the pre-edge inputs.
  always @(posedge clk) begin
    logic [36:0] w;
    bit sel;
    bit full0;
    alu_taken = 0;
    mem_taken = 0;
    if (reset) begin
      mq.delete();
      foreach (cnt[i]) cnt[i] = 0;
    end else begin
      full0 = (mq.size() == DEPTH);
      sel = 0;
      w = '0;
      if (full0) begin
        w = mq.pop_front();
        sel = 1;
      end else if (alu_valid) begin
        w = {alu_rd, alu_data};
        sel = 1;
        alu_taken = 1;
      end else if (mq.size() != 0) begin
        w = mq.pop_front();
        sel = 1;
      end
      if (mem_valid && !full0) begin
        mq.push_back({mem_rd, mem_data});
        mem_taken = 1;
      end
      if (sel) exp_q.push_back(w);
      if (issue_valid) begin
        checks++;
        if (cnt[issue_rd] == 3) begin
          errors++;
          $display("FAIL issue_sat: rd %0d issued with count 3", issue_rd);
        end
      end
      for (int i = 0; i < 32; i++) begin
        automatic bit inc = issue_valid && (int'(issue_rd) == i);
        automatic bit dec = sel && (int'(w[36:32]) == i);
        if (inc && !dec && cnt[i] < 3) cnt[i]++;
        else if (dec && !inc && cnt[i] > 0) cnt[i]--;
      end
    end
  end

  // Monitor: compares DUT outputs against the model each cycle.
  always @(negedge clk) begin
    logic [31:0] bm;
    logic [36:0] e;
    chk("alu_stall", alu_stall, !reset && mq.size() == DEPTH);
    chk("mem_ready", mem_ready, !reset && mq.size() != DEPTH);
    for (int r = 0; r < 32; r++) bm[r] = (cnt[r] != 0);
    chk("busy_mask", busy_mask, bm);
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected",
                 write_address, data_in);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(write_address), 32'(e[36:32]));
        chk("wr_data", data_in, e[31:0]);
      end
    end else begin
      chk("write_enable_idle", 32'(write_enable), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_valid   = 0;
    mem_valid   = 0;
    issue_valid = 0;
  endtask

  initial begin
    reset = 1;
    idle_in();
    alu_rd = 0; alu_data = 0;
    mem_rd = 0; mem_data = 0;
    issue_rd = 0;
    step();
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_addr", 32'(write_address), 0);
    chk("rst_data", data_in, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_alu_stall", 32'(alu_stall), 0);
    step();
    reset = 0;
    step();

    // Single ALU write, latency 1.
    alu_valid = 1; alu_rd = 17; alu_data = 32'h2;
    step();
    alu_valid = 0;
    chk("t1_we", 32'(write_enable), 1);
    chk("t1_addr", 32'(write_address), 17);
    chk("t1_data", data_in, 32'h2);
    step();
    chk("t1_we_low", 32'(write_enable), 0);

    // Load with idle ALU, latency 2.
    mem_valid = 1; mem_rd = 5; mem_data = 32'hDEADBEEF;
    step();
    mem_valid = 0;
    chk("t2_we_wait", 32'(write_enable), 0);
    step();
    chk("t2_we", 32'(write_enable), 1);
    chk("t2_addr", 32'(write_address), 5);
    chk("t2_data", data_in, 32'hDEADBEEF);

    // ALU and load together: ALU first.
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h44;
    step();
    idle_in();
    chk("t2b_first", 32'(write_address), 3);
    step();
    chk("t2b_second", 32'(write_address), 4);
    chk("t2b_second_data", data_in, 32'h44);
    step();
    chk("t2b_idle", 32'(write_enable), 0);

    // Fill FIFO while ALU is continuously valid.
    pushed = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h100;
    mem_valid = 1; mem_rd = 20; mem_data = 32'h200;
    for (int c = 0; c < 20 && pushed < 4; c++) begin
      step();
      if (mem_taken) begin
        pushed++;
        mem_rd = 5'(20 + pushed);
        mem_data = mem_data + 1;
      end
      if (alu_taken) begin
        alu_rd = alu_rd + 1;
        alu_data = alu_data + 1;
      end
      if (pushed == 4) mem_valid = 0;
    end
    chk("t3_pushed", pushed, 4);
    chk("t3_full_ready", 32'(mem_ready), 0);
    chk("t3_full_stall", 32'(alu_stall), 1);
    step();
    chk("t3_stall_pop", 32'(write_address), 20);
    chk("t3_alu_held", 32'(alu_taken), 0);
    for (int c = 0; c < 8; c++) begin
      step();
      if (alu_taken) begin
        alu_rd = alu_rd + 1;
        alu_data = alu_data + 1;
      end
    end
    idle_in();
    repeat (8) step();

    // Scoreboard: two issues, two writes, then same-edge case.
    issue_valid = 1; issue_rd = 9;
    step();
    step();
    issue_valid = 0;
    chk("t4_busy_2", 32'(busy_mask[9]), 1);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h900;
    step();
    alu_data = 32'h901;
    chk("t4_busy_1", 32'(busy_mask[9]), 1);
    step();
    alu_valid = 0;
    chk("t4_busy_0", 32'(busy_mask[9]), 0);
    issue_valid = 1;
    step();
    alu_valid = 1; alu_data = 32'h902;
    step();
    issue_valid = 0; alu_valid = 0;
    chk("t4_same_edge", 32'(busy_mask[9]), 1);
    alu_valid = 1; alu_data = 32'h903;
    step();
    alu_valid = 0;
    chk("t4_final_0", 32'(busy_mask[9]), 0);
    repeat (3) step();

    // Reset with queued loads and pending registers.
    pushed = 0;
    alu_valid = 1; alu_rd = 25; alu_data = 32'h500;
    mem_valid = 1; mem_rd = 13; mem_data = 32'h600;
    issue_valid = 1; issue_rd = 10;
    for (int c = 0; c < 20 && pushed < 3; c++) begin
      step();
      if (mem_taken) begin
        pushed++;
        mem_rd = mem_rd + 1;
        mem_data = mem_data + 1;
      end
      if (alu_taken) begin
        alu_rd = alu_rd + 1;
        alu_data = alu_data + 1;
      end
      issue_rd = issue_rd + 1;
      if (pushed == 3) begin
        mem_valid = 0;
        issue_valid = 0;
      end
    end
    idle_in();
    chk("t5_pushed", pushed, 3);
    chk("t5_busy_pre", 32'(busy_mask[10]), 1);
    reset = 1;
    #1;
    chk("t5_rst_ready", 32'(mem_ready), 0);
    chk("t5_rst_stall", 32'(alu_stall), 0);
    step();
    chk("t5_rst_we", 32'(write_enable), 0);
    chk("t5_rst_busy", busy_mask, 0);
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t5_no_write", 32'(write_enable), 0);
    end

    // Random traffic; ALU payload held until consumed.
    for (int c = 0; c < 10000; c++) begin
      if (!(alu_valid && !alu_taken)) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd = 5'($urandom);
        alu_data = $urandom;
      end
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rd = 5'($urandom);
      mem_data = $urandom;
      issue_rd = 5'($urandom);
      issue_valid = 1'($urandom_range(0, 1)) && (cnt[issue_rd] < 3);
      step();
    end
    idle_in();
    repeat (12) step();
    chk("final_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
